// File: rtl/wf_rgb_pkg.sv
// wf_rgb_pkg: shared FSM encoding and geometry helpers for the RGB matrix driver
package wf_rgb_pkg;
    typedef enum logic [1:0] {IDLE, READ, SHIFT, LATCH} state_e;
    function automatic int shift_bits(input int rows, input int cols);
        return 3 * cols + rows;
    endfunction
    function automatic int pwm_max(input int pwm_bits);
        return (1 << pwm_bits) - 2;
    endfunction
    function automatic int r_off(input int pwm_bits);
        return 2 * pwm_bits;
    endfunction
    function automatic int g_off(input int pwm_bits);
        return pwm_bits;
    endfunction
    function automatic int b_off(input int pwm_bits);
        return 0 * pwm_bits;
    endfunction
    localparam int SHIFT_BITS = shift_bits(8, 8);
    localparam int PWM_MAX = pwm_max(5);
    localparam int R_OFF = r_off(5);
    localparam int G_OFF = g_off(5);
    localparam int B_OFF = b_off(5);
endpackage

// File: rtl/wf_rgb_pwm_if_shifter.sv
// wf_serial_shifter: MSB-first serialiser with CLK_OUT low then high for CLK_DIV clks per bit
module wf_serial_shifter #(
    parameter int W = 32,
    parameter int CLK_DIV = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] word_i,
    output logic         clk_out_o,
    output logic         dout_o,
    output logic         done_o
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(W);
    logic [W-1:0]  sr_q;
    logic [DW-1:0] div_q;
    logic [BW-1:0] bit_q;
    logic          active_q;
    logic          clk_q;
    logic          tick;
    assign tick      = active_q && div_q == DW'(CLK_DIV - 1);
    assign done_o    = tick && clk_q && bit_q == BW'(W - 1);
    assign clk_out_o = clk_q;
    assign dout_o    = sr_q[W-1];
    // Half-period divider: each tick toggles CLK_OUT, a falling tick moves DOUT to the next bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q     <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
            clk_q    <= 1'b0;
        end else if (load_i) begin
            sr_q     <= word_i;
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b1;
            clk_q    <= 1'b0;
        end else if (active_q) begin
            div_q <= tick ? '0 : div_q + DW'(1);
            if (tick) begin
                clk_q <= !clk_q;
                if (done_o) begin
                    active_q <= 1'b0;
                end else if (clk_q) begin
                    bit_q <= bit_q + BW'(1);
                    sr_q  <= {sr_q[W-2:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: rtl/wf_rgb_pwm_if.sv
// wf_rgb_pwm_if: row-scan serial driver for a common-anode RGB matrix with per-channel PWM
import wf_rgb_pkg::*;
module wf_rgb_pwm_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int PWM_BITS = 5,
    parameter int CLK_DIV = 1,
    parameter int ADDR_W = $clog2(ROWS * COLS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    output logic                  busy,
    output logic                  scan_done,
    output logic                  frame_done,
    output logic [ADDR_W-1:0]     ram_rd_addr,
    input  logic [3*PWM_BITS-1:0] ram_rd_pixels,
    output logic                  CLK_OUT,
    output logic                  DOUT,
    output logic                  LOAD
);
    localparam int SB = shift_bits(ROWS, COLS);
    localparam int PMAX = pwm_max(PWM_BITS);
    localparam int RO = r_off(PWM_BITS);
    localparam int GO = g_off(PWM_BITS);
    localparam int BO = b_off(PWM_BITS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS + 1);
    state_e              state_q;
    logic [RW-1:0]       row_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic [CW-1:0]       rd_q;
    logic [COLS-1:0]     r_q, g_q, b_q, r_d, g_d, b_d;
    logic [COLS:0]       rt, gt, bt;
    logic [ADDR_W-1:0]   addr_q;
    logic [SB-1:0]       word;
    logic                busy_q, done_q, frame_q, load_q, cap, sh_load, sh_done;
    assign busy        = busy_q;
    assign scan_done   = done_q;
    assign frame_done  = frame_q;
    assign ram_rd_addr = addr_q;
    assign LOAD        = load_q;
    assign sh_load     = state_q == READ && rd_q == CW'(COLS);
    // Column bit is 0 (sink on) while the channel value exceeds pwm_cnt; columns shift in from the MSB end
    always_comb begin
        cap  = state_q == READ && rd_q != '0;
        rt   = {ram_rd_pixels[RO +: PWM_BITS] <= pwm_q, r_q};
        gt   = {ram_rd_pixels[GO +: PWM_BITS] <= pwm_q, g_q};
        bt   = {ram_rd_pixels[BO +: PWM_BITS] <= pwm_q, b_q};
        r_d  = cap ? rt[COLS:1] : r_q;
        g_d  = cap ? gt[COLS:1] : g_q;
        b_d  = cap ? bt[COLS:1] : b_q;
        word = {g_d, r_d, b_d, ~(ROWS'(1) << row_q)};
    end
    // Scan sequencer: RAM read pipeline, hand-off to the shifter, latch strobe and row/PWM counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            pwm_q   <= '0;
            rd_q    <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            frame_q <= 1'b0;
            load_q  <= 1'b1;
        end else begin
            done_q  <= 1'b0;
            frame_q <= 1'b0;
            case (state_q)
                IDLE: if (scan_en) begin
                    state_q <= READ;
                    busy_q  <= 1'b1;
                    rd_q    <= '0;
                    addr_q  <= ADDR_W'(int'(row_q) * COLS);
                end
                READ: begin
                    r_q  <= r_d;
                    g_q  <= g_d;
                    b_q  <= b_d;
                    rd_q <= rd_q + CW'(1);
                    if (rd_q < CW'(COLS - 1))
                        addr_q <= ADDR_W'(int'(row_q) * COLS + int'(rd_q) + 1);
                    if (sh_load) begin
                        state_q <= SHIFT;
                        load_q  <= 1'b0;
                    end
                end
                SHIFT: if (sh_done) state_q <= LATCH;
                LATCH: begin
                    state_q <= IDLE;
                    load_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (row_q == RW'(ROWS - 1)) begin
                        row_q   <= '0;
                        frame_q <= 1'b1;
                        pwm_q   <= pwm_q == PWM_BITS'(PMAX) ? '0 : pwm_q + PWM_BITS'(1);
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    wf_serial_shifter #(.W(SB), .CLK_DIV(CLK_DIV)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (sh_load),
        .word_i    (word),
        .clk_out_o (CLK_OUT),
        .dout_o    (DOUT),
        .done_o    (sh_done)
    );
endmodule

// File: tb/tb_wf_rgb_pwm_if.sv
// tb_wf_rgb_pwm_if: scoreboard bench for the default matrix and a 4x4 CLK_DIV=3 variant
module tb_wf_rgb_pwm_if;
    typedef struct {
        logic [63:0] w;
        bit          fr;
        int          t0;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        scan_en [2];
    logic        busy [2], sd [2], fd [2], co [2], dout [2], ld [2];
    logic [14:0] mem [2][64];
    logic [63:0] last_w [2];
    int          lat_w [2], nsd [2], nfd [2], pend [2];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int R = k ? 4 : 8;
        localparam int C = k ? 4 : 8;
        localparam int D = k ? 3 : 1;
        localparam int N = 3 * C + R;
        localparam int AW = $clog2(R * C);
        localparam int PM = 30;
        localparam int LAT = 1 + (C + 1) + 2 * D * N + 1;
        logic [AW-1:0] addr;
        logic [14:0]   pix;
        exp_t          q[$];
        exp_t          e;
        logic [63:0]   mw, cap;
        int            cyc = 0, mrow = 0, mpwm = 0, nb = 0, bad = 0, lr = -1, v, sh;
        logic          cop = 1'b0, dp = 1'b0, ldp = 1'b1;

        wf_rgb_pwm_if #(.ROWS(R), .COLS(C), .PWM_BITS(5), .CLK_DIV(D)) dut (
            .clk           (clk),
            .rst_n         (rst_n[k]),
            .scan_en       (scan_en[k]),
            .busy          (busy[k]),
            .scan_done     (sd[k]),
            .frame_done    (fd[k]),
            .ram_rd_addr   (addr),
            .ram_rd_pixels (pix),
            .CLK_OUT       (co[k]),
            .DOUT          (dout[k]),
            .LOAD          (ld[k])
        );

        always @(posedge clk) pix <= mem[k][addr];

        // Reference model: an accepted scan yields the row word from the pixel values and the current PWM level
        always @(posedge clk) begin
            cyc++;
            if (!rst_n[k]) begin
                q.delete();
                mrow = 0;
                mpwm = 0;
            end else if (scan_en[k] && q.size() == 0) begin
                mw = 0;
                for (int j = 0; j < 3; j++) begin
                    sh = j == 0 ? 5 : (j == 1 ? 10 : 0);
                    for (int c = C - 1; c >= 0; c--) begin
                        v = int'(mem[k][mrow * C + c] >> sh) & 31;
                        mw = {mw[62:0], v > mpwm ? 1'b0 : 1'b1};
                    end
                end
                for (int r = R - 1; r >= 0; r--) mw = {mw[62:0], r != mrow};
                q.push_back('{mw, mrow == R - 1, cyc});
                if (mrow == R - 1) mpwm = mpwm == PM ? 0 : mpwm + 1;
                mrow = (mrow + 1) % R;
            end
            pend[k] = q.size();
        end

        // Monitor: collect DOUT on CLK_OUT rises, police timing, and score each scan_done
        always @(negedge clk) begin
            if (!rst_n[k]) begin
                cap = 0;
                nb  = 0;
                bad = 0;
                lr  = -1;
            end else begin
                if (co[k] && !cop) begin
                    cap = {cap[62:0], dout[k]};
                    nb++;
                    if (lr >= 0 && cyc - lr != 2 * D) bad++;
                    lr = cyc;
                end
                if (dout[k] != dp && !ld[k] && !ldp && !(cop && !co[k])) bad++;
                if (fd[k] && !sd[k]) bad++;
                if (fd[k]) nfd[k]++;
                if (sd[k]) begin
                    nsd[k]++;
                    chk("scan_done_expected", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        last_w[k] = cap;
                        lat_w[k] = cyc - e.t0 + 1;
                        chk($sformatf("word%0d", k), cap, e.w);
                        chk($sformatf("latency%0d", k), 64'(lat_w[k]), 64'(LAT));
                        chk($sformatf("bits_frame_timing%0d", k), {32'(nb), 31'(bad), fd[k]}, {32'(N), 31'd0, e.fr});
                    end
                    cap = 0;
                    nb  = 0;
                    bad = 0;
                    lr  = -1;
                end
            end
            cop = co[k];
            dp  = dout[k];
            ldp = ld[k];
        end
    end

    task automatic scan(input int k, input int rp);
        bit got = 0;
        scan_en[k] = 1'b1;
        @(negedge clk);
        for (int n = 1; n < 3000 && !got; n++) begin
            scan_en[k] = n == rp;
            @(negedge clk);
            got = sd[k];
        end
        scan_en[k] = 1'b0;
        chk("scan_done_seen", 64'(got), 64'd1);
        #1;
    endtask

    task automatic do_reset(input int k);
        rst_n[k] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[k] = 1'b1;
    endtask

    initial begin
        int g3 = 0, b0 = 0, rz = 0, s0;
        logic [7:0] rs;
        for (int k = 0; k < 2; k++) begin
            rst_n[k]   = 1'b0;
            scan_en[k] = 1'b0;
            nsd[k] = 0;
            nfd[k] = 0;
            for (int a = 0; a < 64; a++) mem[k][a] = k ? 15'($urandom) : 15'h7FFF;
        end
        repeat (2) @(negedge clk);
        chk("reset_outputs", {ld[0], co[0], dout[0], busy[0], sd[0], fd[0]}, 6'b100000);
        chk("reset_addr", 64'(g[0].addr), 64'd0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        scan(0, 0);
        chk("first_word", last_w[0], 64'h0000_00FE);
        chk("first_latency", 64'(lat_w[0]), 64'd75);
        chk("load_high_after", 64'(ld[0]), 64'd1);
        for (int i = 1; i < 9; i++) begin
            scan(0, $urandom_range(0, 3) == 0 ? $urandom_range(5, 60) : 0);
            rs = 8'h01;
            rs = ~(rs << (i % 8));
            chk("rowsel_seq", 64'(last_w[0][7:0]), 64'(rs));
            if (i == 6) chk("no_frame_before_8", 64'(nfd[0]), 64'd0);
            if (i == 7) chk("frame_on_8th", 64'(nfd[0]), 64'd1);
        end
        do_reset(0);
        for (int a = 0; a < 64; a++) mem[0][a] = 15'h0;
        mem[0][3]  = {5'd0, 5'h1F, 5'd0};
        mem[0][16] = 15'd4;
        for (int i = 0; i < 248; i++) begin
            scan(0, 0);
            if (i % 8 == 0 && last_w[0][31:24] == 8'hF7) g3++;
            if (i % 8 == 0 && (last_w[0][23:16] != 8'hFF || last_w[0][15:8] != 8'hFF)) rz++;
            if (i % 8 == 2 && last_w[0][8] == 1'b0) b0++;
        end
        chk("g_bit3_on_all_frames", 64'(g3), 64'd31);
        chk("r_b_never_on_row0", 64'(rz), 64'd0);
        chk("b4_on_four_frames", 64'(b0), 64'd4);
        for (int a = 0; a < 64; a++) mem[0][a] = 15'($urandom);
        for (int i = 0; i < 16; i++) scan(0, $urandom_range(0, 2) == 0 ? $urandom_range(5, 60) : 0);
        s0 = nsd[0];
        scan(0, 40);
        repeat (150) @(negedge clk);
        chk("repulse_single_done", 64'(nsd[0] - s0), 64'd1);
        scan_en[0] = 1'b1;
        @(negedge clk);
        scan_en[0] = 1'b0;
        repeat (30) @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        chk("mid_shift_reset", {ld[0], co[0], busy[0], sd[0]}, 4'b1000);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        scan(0, 0);
        chk("row0_after_reset", 64'(last_w[0][7:0]), 64'hFE);
        for (int i = 0; i < 10; i++) begin
            scan(1, i == 3 ? 50 : 0);
            chk("latency_div3", 64'(lat_w[1]), 64'd103);
        end
        repeat (20) @(negedge clk);
        chk("pending0", 64'(pend[0]), 64'd0);
        chk("pending1", 64'(pend[1]), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
